sdram_port_arbiter: RTL and testbench
=====================================

// Module: sdram_port_arbiter
// PURPOSE
//  Shares the single-port SDRAM controller between two requesters (p0, p1) with round-robin arbitration.
//  Sequences one transaction at a time: issue, confirm acceptance, wait for completion, acknowledge.
//  Re-issues a request that the controller ignored because it was busy with init or refresh.
//  Sits between the client logic and the controller's wr_*/rd_*/busy interface.
// PARAMETERS
//  HADDR_WIDTH     24  host address width (bank+row+col); must match controller
//  DATA_WIDTH      16  data word width
//  ACCEPT_TIMEOUT  32  cycles in WAIT_ACC without ctl_busy before the enable is re-pulsed (>=16)
// PORTS
//  clk            in   1            sole clock, rising edge
//  rst            in   1            synchronous, active-high reset
//  pN_req         in   1            (N=0,1) request; held high until pN_ack
//  pN_we          in   1            1=write, 0=read; stable while pN_req is high
//  pN_addr        in   HADDR_WIDTH  word address
//  pN_wdata       in   DATA_WIDTH   write data
//  pN_ack         out  1            1-cycle completion pulse
//  pN_rdata       out  DATA_WIDTH   read data; valid in the pN_ack cycle of a read
//  ctl_rd_addr    out  HADDR_WIDTH  to controller rd_addr
//  ctl_wr_addr    out  HADDR_WIDTH  to controller wr_addr
//  ctl_wr_data    out  DATA_WIDTH   to controller wr_data
//  ctl_rd_enable  out  1            to controller rd_enable
//  ctl_wr_enable  out  1            to controller wr_enable
//  ctl_rd_data    in   DATA_WIDTH   from controller rd_data
//  ctl_rd_ready   in   1            from controller rd_ready (1-cycle pulse)
//  ctl_busy       in   1            from controller busy
//  arb_idle       out  1            1 when FSM is in IDLE
// BEHAVIOUR
//  Reset: FSM=IDLE; rr_ptr=0 (p0 preferred); all outputs 0 except arb_idle=1. Reset mid-transaction
//   abandons it; no ack is issued.
//  All outputs are registered. ctl_*_addr both carry the latched address; ctl_wr_data carries the latched wdata.
//  IDLE: if any req is high -> grant. If both are high, the port selected by rr_ptr wins. Latch
//   port id, we, addr, wdata, clear retry counter -> ISSUE.
//  ISSUE (1 cycle): ctl_wr_enable=we or ctl_rd_enable=~we; never both high. Clear timer -> WAIT_ACC.
//  WAIT_ACC: ctl_busy=1 -> WAIT_DONE. Otherwise timer++; timer==ACCEPT_TIMEOUT-1 -> ISSUE (re-pulse).
//   Retries are unlimited.
//  WAIT_DONE: read: ctl_rd_ready=1 -> capture ctl_rd_data into pN_rdata of granted port -> RESP.
//   Write: ctl_busy=0 -> RESP.
//  RESP (1 cycle): pN_ack=1 for the granted port; rr_ptr = other port -> IDLE.
//  Min latency = 8 cycles from req sampled in IDLE to ack, against the TESTING model.
//   The FSM holds with no limit while the controller is slow.
//  Back-to-back: re-request by the same port in the cycle after ack loses to a pending other port.
//  req dropped before ack: the transaction still completes and ack still pulses. pN_rdata of the
//   other port is unchanged.
//  ctl_rd_ready outside WAIT_DONE is ignored. ctl_busy high in IDLE does not block issue; the controller
//   ignores the enable and the timeout retry covers it.
//  Timer width: $clog2(ACCEPT_TIMEOUT)+1 bits; no wrap occurs before the compare.
// CONFIGURATION
//  SDRAM_ARB_STATS_EN defined:
//   Adds outputs p0_grant_cnt, p1_grant_cnt, retry_cnt (16 bits each, saturating at 16'hFFFF).
//   pN_grant_cnt +1 on each RESP for port N; retry_cnt +1 on each WAIT_ACC->ISSUE re-pulse.
//   All three cleared by rst.
//  Undefined: those ports and counters do not exist; behaviour otherwise identical.
// TESTING (controller model: busy rises 2 cycles after enable pulse and falls after completion;
//  rd_ready pulses 6 cycles after enable; enable ignored while model "refreshing")
//  p0 read of 0x000123, model returns 0xBEEF:
//   -> one ctl_rd_enable pulse, ctl_rd_addr=0x000123; p0_ack 8 cycles later with p0_rdata=0xBEEF.
//  p0 write and p1 read raised in the same cycle after reset:
//   -> p0 served first (ctl_wr_enable, wr_data correct); p1 served next; exactly one ack each.
//  Both ports hold req continuously for 6 transactions -> grants alternate p0,p1,p0,p1,p0,p1.
//  Model refreshing for 40 cycles when p1 write issued -> enable re-pulsed at cycles 1, 33, ... until
//   busy rises; single p1_ack; retry_cnt>=1 with SDRAM_ARB_STATS_EN.
//  rst asserted during WAIT_DONE -> next cycle all outputs 0, arb_idle=1, no ack; the next request
//   is served normally.
//  Spurious ctl_rd_ready in IDLE, then p0 read -> p0_rdata takes only the in-transaction ctl_rd_data.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
//   Two-port round-robin front end for a single-port SDRAM controller. Runs one
//   transaction at a time (issue, confirm acceptance, wait for completion, ack)
//   and re-pulses the enable when the controller ignored it during init/refresh.
// Ports
//   clk, rst            clock and synchronous active-high reset
//   pN_req/we/addr/wdata  client request (N=0,1), held until pN_ack
//   pN_ack, pN_rdata      one-cycle completion pulse and read data
//   ctl_*                 controller wr_*/rd_*/busy interface
//   arb_idle              high while the arbiter is idle
// Optional feature
//   SDRAM_ARB_STATS_EN adds saturating p0_grant_cnt, p1_grant_cnt and retry_cnt.
module sdram_port_arbiter #(
  parameter int unsigned HADDR_WIDTH    = 24,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned ACCEPT_TIMEOUT = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   p0_req,
  input  logic                   p0_we,
  input  logic [HADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0]  p0_wdata,
  output logic                   p0_ack,
  output logic [DATA_WIDTH-1:0]  p0_rdata,
  input  logic                   p1_req,
  input  logic                   p1_we,
  input  logic [HADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0]  p1_wdata,
  output logic                   p1_ack,
  output logic [DATA_WIDTH-1:0]  p1_rdata,
  output logic [HADDR_WIDTH-1:0] ctl_rd_addr,
  output logic [HADDR_WIDTH-1:0] ctl_wr_addr,
  output logic [DATA_WIDTH-1:0]  ctl_wr_data,
  output logic                   ctl_rd_enable,
  output logic                   ctl_wr_enable,
  input  logic [DATA_WIDTH-1:0]  ctl_rd_data,
  input  logic                   ctl_rd_ready,
  input  logic                   ctl_busy,
`ifdef SDRAM_ARB_STATS_EN
  output logic [15:0]            p0_grant_cnt,
  output logic [15:0]            p1_grant_cnt,
  output logic [15:0]            retry_cnt,
`endif
  output logic                   arb_idle
);

  localparam int unsigned TW = $clog2(ACCEPT_TIMEOUT) + 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACC, WAIT_DONE, RESP} state_t;

  state_t                 state, state_d;
  logic                   gnt, gnt_d;
  logic                   lat_we, we_d;
  logic                   rr_ptr, rr_d;
  logic [TW-1:0]          timer, timer_d, timer_inc;
  logic [HADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0]  wdata_d;

  assign timer_inc = timer + TW'(1);

  // Next-state and next-value logic; registered outputs are derived from these.
  always_comb begin
    state_d = state;
    gnt_d   = gnt;
    we_d    = lat_we;
    rr_d    = rr_ptr;
    timer_d = timer;
    addr_d  = ctl_rd_addr;
    wdata_d = ctl_wr_data;
    case (state)
      IDLE: begin
        if (p0_req || p1_req) begin
          // p1 wins when it is alone, or when both ask and rr_ptr points at it
          gnt_d   = p1_req && (!p0_req || rr_ptr);
          we_d    = gnt_d ? p1_we    : p0_we;
          addr_d  = gnt_d ? p1_addr  : p0_addr;
          wdata_d = gnt_d ? p1_wdata : p0_wdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT_ACC;
      end
      WAIT_ACC: begin
        if (ctl_busy) begin
          state_d = WAIT_DONE;
        end else if (timer_inc == TW'(ACCEPT_TIMEOUT - 1)) begin
          state_d = ISSUE;
        end else begin
          timer_d = timer_inc;
        end
      end
      WAIT_DONE: begin
        if (lat_we ? !ctl_busy : ctl_rd_ready) state_d = RESP;
      end
      RESP: begin
        rr_d    = ~gnt;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched request and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      gnt           <= 1'b0;
      lat_we        <= 1'b0;
      rr_ptr        <= 1'b0;
      timer         <= '0;
      ctl_rd_addr   <= '0;
      ctl_wr_addr   <= '0;
      ctl_wr_data   <= '0;
      ctl_rd_enable <= 1'b0;
      ctl_wr_enable <= 1'b0;
      p0_ack        <= 1'b0;
      p1_ack        <= 1'b0;
      p0_rdata      <= '0;
      p1_rdata      <= '0;
      arb_idle      <= 1'b1;
    end else begin
      state         <= state_d;
      gnt           <= gnt_d;
      lat_we        <= we_d;
      rr_ptr        <= rr_d;
      timer         <= timer_d;
      ctl_rd_addr   <= addr_d;
      ctl_wr_addr   <= addr_d;
      ctl_wr_data   <= wdata_d;
      ctl_rd_enable <= (state_d == ISSUE) && !we_d;
      ctl_wr_enable <= (state_d == ISSUE) && we_d;
      p0_ack        <= (state_d == RESP) && !gnt_d;
      p1_ack        <= (state_d == RESP) && gnt_d;
      arb_idle      <= (state_d == IDLE);
      // read data is only taken while a read is actually outstanding
      if (state == WAIT_DONE && !lat_we && ctl_rd_ready) begin
        if (gnt) p1_rdata <= ctl_rd_data;
        else     p0_rdata <= ctl_rd_data;
      end
    end
  end

`ifdef SDRAM_ARB_STATS_EN
  // Saturating grant and retry statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      p0_grant_cnt <= '0;
      p1_grant_cnt <= '0;
      retry_cnt    <= '0;
    end else begin
      if (state == RESP && !gnt && p0_grant_cnt != 16'hFFFF) p0_grant_cnt <= p0_grant_cnt + 16'd1;
      if (state == RESP && gnt && p1_grant_cnt != 16'hFFFF)  p1_grant_cnt <= p1_grant_cnt + 16'd1;
      if (state == WAIT_ACC && state_d == ISSUE && retry_cnt != 16'hFFFF) retry_cnt <= retry_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter
//   Drives both ports with directed and random requests against a behavioural
//   SDRAM controller model and an arbitration reference kept in the bench.
module tb_sdram_port_arbiter;
  localparam int unsigned AW = 24;
  localparam int unsigned DW = 16;
  localparam int unsigned TO = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [1:0]    req, we, ack;
  logic [AW-1:0] addr [2];
  logic [DW-1:0] wdata [2];
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic [AW-1:0] ctl_rd_addr, ctl_wr_addr;
  logic [DW-1:0] ctl_wr_data, rd_data;
  logic          ctl_rd_enable, ctl_wr_enable, rd_ready, busy, arb_idle;
`ifdef SDRAM_ARB_STATS_EN
  logic [15:0]   p0_grant_cnt, p1_grant_cnt, retry_cnt;
`endif

  sdram_port_arbiter #(.HADDR_WIDTH(AW), .DATA_WIDTH(DW), .ACCEPT_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .p0_req(req[0]), .p0_we(we[0]), .p0_addr(addr[0]), .p0_wdata(wdata[0]),
    .p0_ack(ack[0]), .p0_rdata(p0_rdata),
    .p1_req(req[1]), .p1_we(we[1]), .p1_addr(addr[1]), .p1_wdata(wdata[1]),
    .p1_ack(ack[1]), .p1_rdata(p1_rdata),
    .ctl_rd_addr(ctl_rd_addr), .ctl_wr_addr(ctl_wr_addr), .ctl_wr_data(ctl_wr_data),
    .ctl_rd_enable(ctl_rd_enable), .ctl_wr_enable(ctl_wr_enable),
    .ctl_rd_data(rd_data), .ctl_rd_ready(rd_ready), .ctl_busy(busy),
`ifdef SDRAM_ARB_STATS_EN
    .p0_grant_cnt(p0_grant_cnt), .p1_grant_cnt(p1_grant_cnt), .retry_cnt(retry_cnt),
`endif
    .arb_idle(arb_idle)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // controller model
  int            age = -1;
  int            refresh_left = 0;
  bit            force_refresh = 0;
  bit            rand_refresh = 0;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] mem [logic [AW-1:0]];

  // arbitration reference
  bit            in_txn = 0;
  int            exp_port = 0;
  int            rr = 0;
  int            first_en_cyc = 0;
  int            pulses = 0;
  int            last_latency = 0;
  int            retries = 0;
  int            acks_total = 0;
  int            grants [2];
  logic [DW-1:0] txn_rdata;
  logic [DW-1:0] exp_rdata [2];
  logic [1:0]    ack_seen;
  bit   [1:0]    dropped;
  int            grant_log [$];
  int            pulse_log [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] rdata_of(input int p);
    return (p == 0) ? p0_rdata : p1_rdata;
  endfunction

  task automatic new_txn(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[p]   = 1'b1;
    we[p]    = w;
    addr[p]  = a;
    wdata[p] = d;
  endtask

  task automatic model_reset();
    in_txn = 0; rr = 0; pulses = 0; retries = 0; acks_total = 0;
    grants[0] = 0; grants[1] = 0;
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    dropped = '0;
    grant_log.delete();
    pulse_log.delete();
  endtask

  // One clock: observe DUT at the falling edge, score it, advance the controller model.
  task automatic step();
    @(negedge clk);
    cyc++;
    ack_seen = '0;
    for (int p = 0; p < 2; p++) begin
      if (ack[p]) begin
        ack_seen[p] = 1'b1;
        check("ack_expected", 32'(in_txn && exp_port == p), 32'd1);
        if (in_txn && exp_port == p) begin
          if (!we[p]) exp_rdata[p] = txn_rdata;
          check("p0_rdata_at_ack", 32'(p0_rdata), 32'(exp_rdata[0]));
          check("p1_rdata_at_ack", 32'(p1_rdata), 32'(exp_rdata[1]));
          last_latency = cyc - first_en_cyc + 1;
          grants[p]++;
          acks_total++;
          rr = 1 - p;
          in_txn = 0;
        end
      end
    end
    if (ctl_rd_enable || ctl_wr_enable) begin
      check("both_enables", 32'(ctl_rd_enable & ctl_wr_enable), 32'd0);
      if (!in_txn) begin
        // requests seen by the grant edge are the ones still driven now
        exp_port = (req[0] && req[1]) ? rr : (req[1] ? 1 : 0);
        in_txn = 1;
        first_en_cyc = cyc;
        pulses = 0;
        grant_log.push_back(exp_port);
        check("grant_had_req", 32'(req[exp_port]), 32'd1);
      end else begin
        retries++;
      end
      pulses++;
      pulse_log.push_back(cyc);
      check("enable_kind", 32'(ctl_wr_enable), 32'(we[exp_port]));
      check("rd_addr", 32'(ctl_rd_addr), 32'(addr[exp_port]));
      check("wr_addr", 32'(ctl_wr_addr), 32'(addr[exp_port]));
      if (we[exp_port]) check("wr_data", 32'(ctl_wr_data), 32'(wdata[exp_port]));
    end
    // controller model
    if (refresh_left > 0) refresh_left--;
    rd_ready = 1'b0;
    if (age >= 0) begin
      age++;
      if (age == 2) busy = 1'b1;
      if (age == 6) begin
        busy = 1'b0;
        age = -1;
        if (m_we) mem[m_addr] = m_wdata;
        else begin
          rd_data   = mem.exists(m_addr) ? mem[m_addr] : DW'($urandom);
          rd_ready  = 1'b1;
          txn_rdata = rd_data;
        end
      end
    end else if (ctl_rd_enable || ctl_wr_enable) begin
      if (force_refresh) begin
        refresh_left = 40;
        force_refresh = 0;
      end
      if (refresh_left == 0) begin
        age = 0; m_we = ctl_wr_enable; m_addr = ctl_rd_addr; m_wdata = ctl_wr_data;
      end
    end else if (rand_refresh && refresh_left == 0 && $urandom_range(0, 63) == 0) begin
      refresh_left = int'($urandom_range(1, 40));
    end
  endtask

  task automatic check_reset_state();
    check("rst_rd_en", 32'(ctl_rd_enable), 32'd0);
    check("rst_wr_en", 32'(ctl_wr_enable), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_p0_rdata", 32'(p0_rdata), 32'd0);
    check("rst_p1_rdata", 32'(p1_rdata), 32'd0);
    check("rst_addr", 32'(ctl_rd_addr | ctl_wr_addr), 32'd0);
    check("rst_wr_data", 32'(ctl_wr_data), 32'd0);
    check("rst_idle", 32'(arb_idle), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0;
    age = -1; refresh_left = 0; busy = 1'b0; rd_ready = 1'b0;
    model_reset();
    step();
    check_reset_state();
    rst = 1'b0;
  endtask

  // Run until no transaction is open and no request is pending; with keep set,
  // acked ports re-request at once until stop_after acks have been seen.
  task automatic run_until_quiet(input int budget, input int stop_after, input bit keep);
    int n = 0;
    bit quiet = 0;
    while (!quiet && n < budget) begin
      step();
      for (int p = 0; p < 2; p++) begin
        if (ack_seen[p]) begin
          if (keep && acks_total < stop_after) new_txn(p, we[p], addr[p] + AW'(1), wdata[p] + DW'(1));
          else req[p] = 1'b0;
        end
      end
      if (keep && acks_total >= stop_after) req = '0;
      quiet = !in_txn && req == '0;
      n++;
    end
    check("quiet_timeout", 32'(quiet), 32'd1);
  endtask

  initial begin
    rst = 1'b1; req = '0; we = '0;
    addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
    busy = 1'b0; rd_ready = 1'b0; rd_data = '0;
    do_reset();

    // p0 read of 0x000123 returning 0xBEEF
    mem[AW'(24'h000123)] = 16'hBEEF;
    new_txn(0, 1'b0, AW'(24'h000123), '0);
    run_until_quiet(100, 1, 0);
    check("read_latency", 32'(last_latency), 32'd8);
    check("read_pulses", 32'(pulses), 32'd1);
    check("read_rdata", 32'(p0_rdata), 32'hBEEF);

    // simultaneous p0 write and p1 read of the same word
    do_reset();
    new_txn(0, 1'b1, AW'(24'h000010), 16'hA5A5);
    new_txn(1, 1'b0, AW'(24'h000010), '0);
    run_until_quiet(200, 2, 0);
    check("simul_count", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() == 2) begin
      check("simul_first", 32'(grant_log[0]), 32'd0);
      check("simul_second", 32'(grant_log[1]), 32'd1);
    end
    check("simul_p1_rdata", 32'(p1_rdata), 32'hA5A5);
    check("simul_latency", 32'(last_latency), 32'd8);

    // both ports hold requests for six transactions
    do_reset();
    new_txn(0, 1'b1, AW'(24'h000200), 16'h0100);
    new_txn(1, 1'b0, AW'(24'h000200), '0);
    run_until_quiet(400, 6, 1);
    check("rr_count", 32'(grant_log.size()), 32'd6);
    foreach (grant_log[i]) check("rr_order", 32'(grant_log[i]), 32'(i % 2));

    // controller refreshing for 40 cycles when p1 write is issued
    do_reset();
    force_refresh = 1;
    new_txn(1, 1'b1, AW'(24'h000777), 16'h5A5A);
    run_until_quiet(300, 1, 0);
    check("retry_pulses", 32'(pulse_log.size()), 32'd3);
    if (pulse_log.size() == 3) begin
      check("retry_gap1", 32'(pulse_log[1] - pulse_log[0]), 32'd32);
      check("retry_gap2", 32'(pulse_log[2] - pulse_log[1]), 32'd32);
    end
    check("retry_acks", 32'(grants[1]), 32'd1);
    check("retry_mem", 32'(mem[AW'(24'h000777)]), 32'h5A5A);
`ifdef SDRAM_ARB_STATS_EN
    step();
    check("retry_cnt", 32'(retry_cnt), 32'd2);
    check("p1_grant_cnt", 32'(p1_grant_cnt), 32'd1);
`endif
    for (int i = 0; i < 20; i++) step();

    // reset while waiting for read completion
    do_reset();
    new_txn(0, 1'b0, AW'(24'h000005), '0);
    for (int i = 0; i < 20 && !in_txn; i++) step();
    check("midrst_started", 32'(in_txn), 32'd1);
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1; req = '0;
    model_reset();
    step();
    check_reset_state();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) step();
    check("midrst_no_ack", 32'(acks_total), 32'd0);
    new_txn(1, 1'b1, AW'(24'h000006), 16'h1357);
    run_until_quiet(100, 1, 0);
    check("midrst_next_latency", 32'(last_latency), 32'd8);
    check("midrst_next_ack", 32'(grants[1]), 32'd1);

    // spurious rd_ready while idle
    do_reset();
    rd_data = 16'hDEAD; rd_ready = 1'b1;
    step();
    step();
    check("spurious_ignored", 32'(p0_rdata), 32'd0);
    mem[AW'(24'h000040)] = 16'h1234;
    new_txn(0, 1'b0, AW'(24'h000040), '0);
    run_until_quiet(100, 1, 0);
    check("spurious_rdata", 32'(p0_rdata), 32'h1234);

    // random traffic with random refresh windows and early request drops
    do_reset();
    rand_refresh = 1;
    for (int i = 0; i < 3000; i++) begin
      step();
      for (int p = 0; p < 2; p++) begin
        if (ack_seen[p]) begin
          dropped[p] = 1'b0;
          if ($urandom_range(0, 1) == 1)
            new_txn(p, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
          else req[p] = 1'b0;
        end else if (!req[p] && !dropped[p] && $urandom_range(0, 2) == 0) begin
          new_txn(p, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
        end else if (req[p] && in_txn && exp_port == p && $urandom_range(0, 19) == 0) begin
          req[p] = 1'b0;
          dropped[p] = 1'b1;
        end
      end
    end
    req = '0;
    run_until_quiet(600, 0, 0);
    check("random_both_served", 32'(grants[0] > 10 && grants[1] > 10), 32'd1);
`ifdef SDRAM_ARB_STATS_EN
    step();
    check("rand_p0_grant_cnt", 32'(p0_grant_cnt), 32'(grants[0]));
    check("rand_p1_grant_cnt", 32'(p1_grant_cnt), 32'(grants[1]));
    check("rand_retry_cnt", 32'(retry_cnt), 32'(retries));
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
